// File: rtl/spi_master_sched.sv
// spi_master_sched: round-robin scheduler that shares one SPI bus between NUM_REQ requesters.
// Per grant it drives cs_n/sck/mosi for DATA_LEN bits, gates the receiver and reports its word or a timeout.
module spi_master_sched #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_LEN   = 8,
    parameter int HALF_DIV   = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int RX_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_LEN-1:0]   tx_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          busy,
    output logic                          done,
    output logic [DATA_LEN-1:0]           rx_word,
    output logic                          timeout,
    output logic                          sck,
    output logic                          mosi,
    output logic [NUM_REQ-1:0]            cs_n,
    output logic                          rx_en,
    input  logic                          rx_qvld,
    input  logic [DATA_LEN-1:0]           rx_dout
);
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BIT_W   = $clog2(DATA_LEN + 1);
    localparam int MAX_A   = (HALF_DIV > CS_SETUP) ? HALF_DIV : CS_SETUP;
    localparam int MAX_B   = (CS_HOLD > RX_TIMEOUT) ? CS_HOLD : RX_TIMEOUT;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_WAIT_RX,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W-1:0]       gidx_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [BIT_W-1:0]       bit_cnt_q;
    logic [DATA_LEN-1:0]    sh_q;
    logic [DATA_LEN-1:0]    rx_word_q;
    logic [NUM_REQ-1:0]     gnt_q;
    logic [NUM_REQ-1:0]     cs_n_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   timeout_q;
    logic                   sck_q;
    logic                   rx_en_q;
    logic                   rx_got_q;

    logic                   pick_vld;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       scan_idx;
    logic [DATA_LEN-1:0]    pick_word;

    // Scan downwards from ptr+NUM_REQ-1 so the last hit is the first set bit at or after ptr.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pick_vld  = 1'b0;
        pick_idx  = '0;
        scan_idx  = '0;
        pick_word = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (req[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) pick_word = tx_data[i*DATA_LEN +: DATA_LEN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gidx_q    <= '0;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            rx_word_q <= '0;
            gnt_q     <= '0;
            cs_n_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            sck_q     <= 1'b0;
            rx_en_q   <= 1'b0;
            rx_got_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        gidx_q    <= pick_idx;
                        gnt_q     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        cs_n_q    <= ~({{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx);
                        busy_q    <= 1'b1;
                        rx_en_q   <= 1'b1;
                        sh_q      <= pick_word;
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        rx_got_q  <= 1'b0;
                        state_q   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                        cnt_q   <= '0;
                        sck_q   <= 1'b1;
                        state_q <= S_HIGH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (cnt_q == CNT_W'(HALF_DIV - 1)) begin
                        cnt_q   <= '0;
                        sck_q   <= 1'b0;
                        state_q <= S_LOW;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_LOW: begin
                    if (cnt_q == CNT_W'(HALF_DIV - 1)) begin
                        cnt_q     <= '0;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_W'(DATA_LEN - 1)) begin
                            state_q <= S_HOLD;
                        end else begin
                            // mosi moves only here, together with the rising sck edge.
                            sh_q    <= {sh_q[DATA_LEN-2:0], 1'b0};
                            sck_q   <= 1'b1;
                            state_q <= S_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (rx_qvld) begin
                        rx_word_q <= rx_dout;
                        rx_got_q  <= 1'b1;
                    end
                    if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
                        cnt_q   <= '0;
                        cs_n_q  <= '1;
                        state_q <= S_WAIT_RX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WAIT_RX: begin
                    if (rx_got_q || rx_qvld || cnt_q == CNT_W'(RX_TIMEOUT - 1)) begin
                        if (!rx_got_q) begin
                            if (rx_qvld) begin
                                rx_word_q <= rx_dout;
                            end else begin
                                rx_word_q <= '0;
                                timeout_q <= 1'b1;
                            end
                        end
                        done_q  <= 1'b1;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        rx_en_q <= 1'b0;
                        sh_q    <= '0;
                        ptr_q   <= (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_word = rx_word_q;
    assign timeout = timeout_q;
    assign sck     = sck_q;
    assign mosi    = sh_q[DATA_LEN-1];
    assign cs_n    = cs_n_q;
    assign rx_en   = rx_en_q;

endmodule

// File: tb/tb_spi_master_sched.sv
// Scoreboard bench for spi_master_sched: a default instance (2x8 bit) and a 3x12 bit, HALF_DIV=2 instance.
// Stimulus pushes expected transactions; a negedge monitor observes the bus and pops on every done.
module tb_spi_master_sched;
    logic        clk;
    logic        rst;

    logic [1:0]  req_a;
    logic [15:0] tx_data_a;
    logic [1:0]  gnt_a;
    logic        busy_a, done_a, timeout_a, sck_a, mosi_a, rx_en_a, rx_qvld_a;
    logic [7:0]  rx_word_a, rx_dout_a;
    logic [1:0]  cs_n_a;

    logic [2:0]  req_b;
    logic [35:0] tx_data_b;
    logic [2:0]  gnt_b;
    logic        busy_b, done_b, timeout_b, sck_b, mosi_b, rx_en_b, rx_qvld_b;
    logic [11:0] rx_word_b, rx_dout_b;
    logic [2:0]  cs_n_b;

    spi_master_sched dut_a (
        .clk(clk), .rst(rst), .req(req_a), .tx_data(tx_data_a), .gnt(gnt_a), .busy(busy_a),
        .done(done_a), .rx_word(rx_word_a), .timeout(timeout_a), .sck(sck_a), .mosi(mosi_a),
        .cs_n(cs_n_a), .rx_en(rx_en_a), .rx_qvld(rx_qvld_a), .rx_dout(rx_dout_a)
    );

    spi_master_sched #(.NUM_REQ(3), .DATA_LEN(12), .HALF_DIV(2)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .tx_data(tx_data_b), .gnt(gnt_b), .busy(busy_b),
        .done(done_b), .rx_word(rx_word_b), .timeout(timeout_b), .sck(sck_b), .mosi(mosi_b),
        .cs_n(cs_n_b), .rx_en(rx_en_b), .rx_qvld(rx_qvld_b), .rx_dout(rx_dout_b)
    );

    typedef struct {
        logic [7:0]  gnt;
        logic [31:0] tx;
        logic [31:0] rx;
        logic        to;
        int          wait_c;
        int          nbits;
        int          hd;
        int          blen;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          errors  = 0;
    int          done_count = 0;
    logic        sel_b = 1'b0;
    logic        check_gap = 1'b0;
    logic        resp_on = 1'b1;
    logic [31:0] rx_tab [3];
    int          mon_gidx = 0;

    logic        mon_busy, mon_done, mon_sck, mon_mosi, mon_to, mon_cs_idle;
    logic [7:0]  mon_gnt;
    logic [31:0] mon_rx;
    assign mon_busy    = sel_b ? busy_b : busy_a;
    assign mon_done    = sel_b ? done_b : done_a;
    assign mon_sck     = sel_b ? sck_b : sck_a;
    assign mon_mosi    = sel_b ? mosi_b : mosi_a;
    assign mon_to      = sel_b ? timeout_b : timeout_a;
    assign mon_cs_idle = sel_b ? (&cs_n_b) : (&cs_n_a);
    assign mon_gnt     = sel_b ? {5'b0, gnt_b} : {6'b0, gnt_a};
    assign mon_rx      = sel_b ? {20'b0, rx_word_b} : {24'b0, rx_word_a};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int gidx, input logic [31:0] tx, input logic [31:0] rx,
                            input logic to, input int wait_c);
        exp_t e;
        e.gnt    = 8'(1) << gidx;
        e.tx     = tx;
        e.rx     = rx;
        e.to     = to;
        e.wait_c = wait_c;
        e.nbits  = sel_b ? 12 : 8;
        e.hd     = sel_b ? 2 : 4;
        e.blen   = 2 + 2 * e.hd * e.nbits + 2 + wait_c;
        exp_q.push_back(e);
    endtask

    // Monitor: tracks one transaction from busy rise to done and scores it.
    logic        in_txn = 1'b0, gap_active = 1'b0, prev_sck = 1'b0;
    logic [7:0]  cur_gnt;
    logic [31:0] bits;
    int          nbits, hi_run, hi_min, hi_max, busy_len, wait_cnt, since_done;
    always @(negedge clk) begin
        if (rst) begin
            in_txn = 1'b0; gap_active = 1'b0; prev_sck = 1'b0; hi_run = 0;
        end else begin
            if (gap_active) since_done++;
            if (mon_busy && !in_txn) begin
                in_txn = 1'b1; cur_gnt = mon_gnt; bits = '0; nbits = 0; hi_run = 0;
                hi_min = 1000; hi_max = 0; busy_len = 0; wait_cnt = 0;
                for (int i = 0; i < 8; i++) if (mon_gnt[i]) mon_gidx = i;
                if (gap_active && check_gap) check("done_to_next_grant_gap", since_done, 2);
                gap_active = 1'b0;
            end
            if (mon_busy) begin
                busy_len++;
                if (mon_cs_idle) wait_cnt++;
            end
            if (mon_sck) hi_run++;
            if (prev_sck && !mon_sck) begin
                bits = {bits[30:0], mon_mosi};
                nbits++;
                if (hi_run < hi_min) hi_min = hi_run;
                if (hi_run > hi_max) hi_max = hi_run;
                hi_run = 0;
            end
            prev_sck = mon_sck;
            if (mon_done) begin
                done_count++;
                in_txn = 1'b0; gap_active = 1'b1; since_done = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("grant", cur_gnt, e.gnt);
                    check("mosi_word", bits, e.tx);
                    check("sck_pulses", nbits, e.nbits);
                    check("sck_high_min", hi_min, e.hd);
                    check("sck_high_max", hi_max, e.hd);
                    check("busy_cycles", busy_len, e.blen);
                    check("wait_rx_cycles", wait_cnt, e.wait_c);
                    check("rx_word", mon_rx, e.rx);
                    check("timeout", mon_to, e.to);
                end
            end
        end
    end

    // Loopback receiver: one rx_qvld pulse once cs_n has gone back high during the transaction.
    logic sent = 1'b0;
    initial begin
        rx_qvld_a = 1'b0; rx_qvld_b = 1'b0; rx_dout_a = '0; rx_dout_b = '0;
        forever begin
            @(negedge clk);
            rx_qvld_a = 1'b0; rx_qvld_b = 1'b0;
            if (!mon_busy) sent = 1'b0;
            if (resp_on && mon_busy && mon_cs_idle && !sent && !rst) begin
                sent = 1'b1;
                rx_dout_a = rx_tab[mon_gidx][7:0];
                rx_dout_b = rx_tab[mon_gidx][11:0];
                if (sel_b) rx_qvld_b = 1'b1; else rx_qvld_a = 1'b1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_busy(input string what);
        int n = 0;
        while (!mon_busy && n < 50) begin tick(); n++; end
        if (!mon_busy) check({what, "_busy_wait_expired"}, 0, 1);
    endtask

    task automatic wait_dones(input int target, input string what);
        int n = 0;
        while (done_count < target && n < 2000) begin tick(); n++; end
        if (done_count < target) check({what, "_done_wait_expired"}, done_count, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        int rises;
        logic ps;
        rst = 1'b1; req_a = '0; req_b = '0; tx_data_a = '0; tx_data_b = '0;
        rx_tab[0] = '0; rx_tab[1] = '0; rx_tab[2] = '0;
        tick(); tick();
        check("reset_gnt",   {gnt_b, 2'b0} | {3'b0, gnt_a}, 0);
        check("reset_flags", {busy_a, done_a, timeout_a, sck_a, mosi_a, rx_en_a,
                              busy_b, done_b, timeout_b, sck_b, mosi_b, rx_en_b}, 0);
        check("reset_cs_n",  {cs_n_b, cs_n_a}, 5'b11111);
        check("reset_rx_word", {rx_word_b, rx_word_a}, 0);
        rst = 1'b0;
        tick();

        // 1: single request, A5 out, 3C back; req dropped once granted.
        tx_data_a[7:0] = 8'hA5; rx_tab[0] = 32'h3C;
        push_exp(0, 32'hA5, 32'h3C, 1'b0, 1);
        target = done_count + 1;
        req_a = 2'b01;
        wait_busy("t1");
        check("t1_cs_n", cs_n_a, 2'b10);
        req_a = 2'b00;
        wait_dones(target, "t1");

        // 2: both requesting continuously; ptr=1 after test 1 so rotation starts at 1.
        tx_data_a = {8'hC3, 8'h0F}; rx_tab[0] = 32'h81; rx_tab[1] = 32'h7E;
        push_exp(1, 32'hC3, 32'h7E, 1'b0, 1);
        push_exp(0, 32'h0F, 32'h81, 1'b0, 1);
        push_exp(1, 32'hC3, 32'h7E, 1'b0, 1);
        push_exp(0, 32'h0F, 32'h81, 1'b0, 1);
        target = done_count + 4;
        req_a = 2'b11;
        wait_busy("t2");
        check_gap = 1'b1;
        wait_dones(target, "t2");
        req_a = 2'b00; check_gap = 1'b0;
        repeat (3) tick();

        // 3: no rx_qvld -> timeout after 16 wait cycles, then a normal transaction.
        resp_on = 1'b0; tx_data_a[7:0] = 8'h96;
        push_exp(0, 32'h96, 32'h0, 1'b1, 16);
        target = done_count + 1;
        req_a = 2'b01;
        wait_dones(target, "t3");
        req_a = 2'b00; resp_on = 1'b1;
        tick();
        tx_data_a[7:0] = 8'hE1; rx_tab[0] = 32'h55;
        push_exp(0, 32'hE1, 32'h55, 1'b0, 1);
        target = done_count + 1;
        req_a = 2'b01;
        wait_dones(target, "t3b");
        req_a = 2'b00;
        tick();

        // 4: abort at the 3rd sck high; ptr is 1 beforehand, so req=11 afterwards proves it reset to 0.
        req_a = 2'b01;
        rises = 0; ps = 1'b0;
        for (int n = 0; n < 200 && rises < 3; n++) begin
            tick();
            if (sck_a && !ps) rises++;
            ps = sck_a;
        end
        check("t4_third_sck_seen", rises, 3);
        rst = 1'b1;
        #1;
        check("t4_abort_outputs", {sck_a, rx_en_a, busy_a, done_a}, 0);
        check("t4_abort_cs_n", cs_n_a, 2'b11);
        req_a = 2'b00;
        tick(); tick();
        rst = 1'b0;
        tick();
        tx_data_a = {8'h99, 8'h24}; rx_tab[0] = 32'h42; rx_tab[1] = 32'h66;
        push_exp(0, 32'h24, 32'h42, 1'b0, 1);
        target = done_count + 1;
        req_a = 2'b11;
        wait_busy("t4");
        req_a = 2'b00;
        wait_dones(target, "t4");
        tick();
        push_exp(1, 32'h99, 32'h66, 1'b0, 1);
        target = done_count + 1;
        req_a = 2'b10;
        wait_dones(target, "t4b");
        req_a = 2'b00;
        tick();

        // 5: req dropped and tx_data overwritten mid-transfer; the latched 5A must go out.
        tx_data_a[15:8] = 8'h5A; rx_tab[1] = 32'hA0;
        push_exp(1, 32'h5A, 32'hA0, 1'b0, 1);
        target = done_count + 1;
        req_a = 2'b10;
        wait_busy("t5");
        req_a = 2'b00;
        repeat (20) tick();
        tx_data_a = 16'hFFFF;
        wait_dones(target, "t5");
        tick();

        // 6: 3 requesters, 12-bit words, HALF_DIV=2: rotation 0,1,2,0.
        sel_b = 1'b1;
        tick();
        tx_data_b = {12'h0F1, 12'h5A3, 12'hABC};
        rx_tab[0] = 32'h123; rx_tab[1] = 32'h456; rx_tab[2] = 32'h789;
        push_exp(0, 32'hABC, 32'h123, 1'b0, 1);
        push_exp(1, 32'h5A3, 32'h456, 1'b0, 1);
        push_exp(2, 32'h0F1, 32'h789, 1'b0, 1);
        push_exp(0, 32'hABC, 32'h123, 1'b0, 1);
        target = done_count + 4;
        req_b = 3'b111;
        wait_busy("t6");
        check_gap = 1'b1;
        wait_dones(target, "t6");
        req_b = 3'b000; check_gap = 1'b0;
        repeat (5) tick();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
